mem_wait_responder: RTL and testbench

//  Memory-side responder for the CPU's data/instruction accesses: byte-addressed
//  RAM behind a req/ack handshake with a programmable number of wait states.
//  It replaces the fixed one-cycle memory when the control unit is built to stall
//  on ack. It also lets the datapath be tested against slow memory. Little-endian.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_byte_array.sv | 33 +++
 rtl/mem_wait_responder.sv | 191 +++++++++++++++++++
 tb/tb_mem_wait_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state memory responder: access size codes,
// FSM state encoding, wait-counter width and access decode helpers.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_WORD: n = 3'd4;
            SZ_HALF: n = 3'd2;
            SZ_BYTE: n = 3'd1;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Misaligned word/half or the reserved size code make the access illegal.
    function automatic logic access_err(input logic [1:0] sz, input logic [1:0] lo);
        logic e;
        case (sz)
            SZ_WORD: e = (lo != 2'b00);
            SZ_HALF: e = lo[0];
            SZ_BYTE: e = 1'b0;
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// DEPTH x 8 storage with four byte lanes; each lane has a combinational read
// port and a byte-enabled write port sharing one already-wrapped index.
module mem_byte_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic                 clk_i,
    input  logic [4*IDX_W-1:0]   lane_idx_i,
    input  logic [3:0]           wr_en_i,
    input  logic [31:0]          wr_data_i,
    output logic [31:0]          rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Byte-enabled write of up to four lanes.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_i[i]) begin
                mem_q[lane_idx_i[IDX_W*i +: IDX_W]] <= wr_data_i[8*i +: 8];
            end
        end
    end

    // Combinational read of all four lanes.
    always_comb begin
        rd_data_o = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            rd_data_o[8*i +: 8] = mem_q[lane_idx_i[IDX_W*i +: IDX_W]];
        end
    end

endmodule

// File: rtl/mem_wait_responder.sv
// Byte-addressed little-endian RAM behind a req/ack handshake with a fixed number
// of wait states; flags misaligned or reserved-size accesses with err.
module mem_wait_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              busy_o,
    output logic              ack_o,
    output logic              err_o
);

    localparam int             IDX_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q;
    logic [1:0]         size_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;

    logic               acc_we_s;
    logic [1:0]         acc_size_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [31:0]        acc_wdata_s;
    logic               acc_err_s;
    logic [2:0]         nbytes_s;
    logic [3:0]         lane_en_s;
    logic [3:0]         wr_en_s;
    logic [4*IDX_W-1:0] lane_idx_s;
    logic [31:0]        rd_lane_s;
    logic [31:0]        rd_masked_s;

    logic [31:0]        rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    logic unused_addr_s;
    assign unused_addr_s = ^addr_i[ADDR_W-1:IDX_W];

    // FSM state and wait counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, count down in WAIT, RESP lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches, loaded on the accepting edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            idx_q   <= {IDX_W{1'b0}};
            wdata_q <= 32'h0000_0000;
        end else if ((state_q == ST_IDLE) && req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            idx_q   <= addr_i[IDX_W-1:0];
            wdata_q <= wdata_i;
        end else begin
            we_q    <= we_q;
            size_q  <= size_q;
            idx_q   <= idx_q;
            wdata_q <= wdata_q;
        end
    end

    // With zero wait states the access completes on its accepting edge, so the
    // live request is used while still in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we_s    = we_i;
            acc_size_s  = size_i;
            acc_idx_s   = addr_i[IDX_W-1:0];
            acc_wdata_s = wdata_i;
        end else begin
            acc_we_s    = we_q;
            acc_size_s  = size_q;
            acc_idx_s   = idx_q;
            acc_wdata_s = wdata_q;
        end
        acc_err_s = access_err(acc_size_s, acc_idx_s[1:0]);
        nbytes_s  = size_bytes(acc_size_s);
    end

    // Lane steering: lane i addresses byte (addr + i) wrapped to DEPTH.
    always_comb begin
        lane_idx_s  = {(4*IDX_W){1'b0}};
        lane_en_s   = 4'b0000;
        wr_en_s     = 4'b0000;
        rd_masked_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            lane_idx_s[IDX_W*i +: IDX_W] = acc_idx_s + IDX_W'(i);
            lane_en_s[i]   = (3'(i) < nbytes_s);
            wr_en_s[i]     = ack_d && !reset_i && acc_we_s && !acc_err_s && lane_en_s[i];
            rd_masked_s[8*i +: 8] = lane_en_s[i] ? rd_lane_s[8*i +: 8] : 8'h00;
        end
    end

    mem_byte_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i      (clk_i),
        .lane_idx_i (lane_idx_s),
        .wr_en_i    (wr_en_s),
        .wr_data_i  (acc_wdata_s),
        .rd_data_o  (rd_lane_s)
    );

    // Output decode from the next state; rdata loads on the edge raising ack.
    always_comb begin
        busy_d = (state_d == ST_WAIT);
        ack_d  = (state_d == ST_RESP);
        err_d  = ack_d && acc_err_s;
        if (ack_d) begin
            if (acc_err_s) begin
                rdata_d = 32'h0000_0000;
            end else if (!acc_we_s) begin
                rdata_d = rd_masked_s;
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rdata_q <= 32'h0000_0000;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: one instance with one wait state and one with
// none, driven by directed and random accesses against a byte-array model.
module tb_mem_wait_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    bit          sel = 1'b1;

    logic        req0, req1;
    logic [31:0] rdata0, rdata1;
    logic        busy0, busy1, ack0, ack1, err0, err1;
    logic [31:0] rdata_s;
    logic        busy_s, ack_s, err_s;

    int n_vec = 0;
    int n_err = 0;
    int wc [2] = '{0, 1};
    logic [7:0]  ref_mem [2][256];
    logic [31:0] exp_rdata [2];

    assign req0    = req & ~sel;
    assign req1    = req & sel;
    assign rdata_s = sel ? rdata1 : rdata0;
    assign busy_s  = sel ? busy1 : busy0;
    assign ack_s   = sel ? ack1 : ack0;
    assign err_s   = sel ? err1 : err0;

    always #5 clk = ~clk;

    mem_wait_responder #(.DEPTH(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clk_i(clk), .reset_i(reset), .req_i(req0), .we_i(we), .size_i(size),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata0), .busy_o(busy0),
        .ack_o(ack0), .err_o(err0));

    mem_wait_responder #(.DEPTH(256), .WAIT_CYCLES(1), .ADDR_W(32)) dut1 (
        .clk_i(clk), .reset_i(reset), .req_i(req1), .we_i(we), .size_i(size),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1), .busy_o(busy1),
        .ack_o(ack1), .err_o(err1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte i of the access lives at (addr + i) mod 256.
    task automatic model_access(input int d, input logic w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
        int n;
        int idx;
        n = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 0;
        e = (n == 0) ? 1'b1 : ((a % n) != 0);
        rd = exp_rdata[d];
        if (e) begin
            rd = 32'h0;
        end else if (w) begin
            for (int i = 0; i < n; i++) begin
                idx = int'((a + 32'(i)) % 32'd256);
                ref_mem[d][idx] = wd[8*i +: 8];
            end
        end else begin
            rd = 32'h0;
            for (int i = 0; i < n; i++) begin
                idx = int'((a + 32'(i)) % 32'd256);
                rd[8*i +: 8] = ref_mem[d][idx];
            end
        end
        exp_rdata[d] = rd;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] s);
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (s == 2'b00) a[1:0] = 2'b00;
            if (s == 2'b01) a[0] = 1'b0;
        end
        return a;
    endfunction

    // One handshaked access, started on a negedge with the target idle.
    task automatic do_access(input int d, input logic w, input logic [1:0] s,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] obs_rd);
        logic        e;
        logic [31:0] exp_rd;
        int          k;
        bit          seen;
        sel = (d == 1); req = 1'b1; we = w; size = s; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = $urandom; size = 2'($urandom); addr = $urandom; wdata = $urandom;
        model_access(d, w, s, a, wd, e, exp_rd);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            if (ack_s) begin
                seen = 1'b1;
            end else begin
                check("busy_in_wait", 32'(busy_s), 32'd1);
                k++;
                @(negedge clk);
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        obs_rd = rdata_s;
        if (seen) begin
            check("ack_latency", 32'(k), 32'(wc[d]));
            check("busy_at_ack", 32'(busy_s), 32'd0);
            check("err", 32'(err_s), 32'(e));
            check("rdata", rdata_s, exp_rd);
        end
        @(negedge clk);
        check("ack_pulse", 32'(ack_s), 32'd0);
    endtask

    initial begin
        logic [31:0] obs;
        logic        e;
        logic [31:0] exp_rd;
        logic        pw;
        logic [1:0]  ps;
        logic [31:0] pa, pd;

        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;

        // 1: reset, then idle
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy1), 32'd0);
            check("idle_ack", 32'(ack1), 32'd0);
            check("idle_err", 32'(err1), 32'd0);
            check("idle_rdata", rdata1, 32'h0);
        end

        // Prefill both memories so every later read has a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 64; w++) begin
                do_access(d, 1'b1, 2'b00, 32'(4 * w), $urandom, obs);
            end
        end

        // 2: word write / read, byte read
        do_access(1, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, obs);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, obs);
        check("t2_word", obs, 32'hDEADBEEF);
        do_access(1, 1'b0, 2'b10, 32'h13, 32'h0, obs);
        check("t2_byte", obs, 32'h000000DE);

        // 3: half write over a word
        do_access(1, 1'b1, 2'b00, 32'h20, 32'hAABBCCDD, obs);
        do_access(1, 1'b1, 2'b01, 32'h22, 32'h00001234, obs);
        do_access(1, 1'b0, 2'b00, 32'h20, 32'h0, obs);
        check("t3_merge", obs, 32'h1234CCDD);

        // 4: misaligned and reserved-size accesses
        do_access(1, 1'b0, 2'b00, 32'h11, 32'h0, obs);
        check("t4_misalign_rdata", obs, 32'h0);
        do_access(1, 1'b1, 2'b11, 32'h10, 32'hFFFFFFFF, obs);
        do_access(1, 1'b1, 2'b01, 32'h13, 32'hFFFFFFFF, obs);
        do_access(1, 1'b0, 2'b00, 32'h10, 32'h0, obs);
        check("t4_unchanged", obs, 32'hDEADBEEF);

        // 5: address wrap
        do_access(1, 1'b1, 2'b10, 32'h1FF, 32'h0000005A, obs);
        do_access(1, 1'b0, 2'b10, 32'hFF, 32'h0, obs);
        check("t5_wrap", obs, 32'h0000005A);

        // 6: reset during the wait cycle of a word write
        sel = 1'b1; req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h40; wdata = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        check("t6_busy", 32'(busy1), 32'd1);
        reset = 1'b1; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        check("t6_ack", 32'(ack1), 32'd0);
        check("t6_busy_rst", 32'(busy1), 32'd0);
        check("t6_err", 32'(err1), 32'd0);
        check("t6_rdata", rdata1, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_no_ack", 32'(ack1), 32'd0);
        end
        do_access(1, 1'b0, 2'b00, 32'h40, 32'h0, obs);
        check("t6_old", obs, {ref_mem[1][67], ref_mem[1][66], ref_mem[1][65], ref_mem[1][64]});

        // Random traffic, one wait state
        for (int t = 0; t < 40; t++) begin
            ps = 2'($urandom_range(0, 3));
            do_access(1, 1'($urandom), ps, rand_addr(ps), $urandom, obs);
        end

        // 7: req held high with zero wait states; junk driven in RESP cycles
        sel = 1'b0;
        pw = 1'b0; ps = 2'b00; pa = 32'h0; pd = 32'h0;
        for (int k = 0; k < 80; k++) begin
            check("t7_busy", 32'(busy0), 32'd0);
            if (k % 2 == 0) begin
                check("t7_idle_ack", 32'(ack0), 32'd0);
                pw = 1'($urandom);
                ps = 2'($urandom_range(0, 3));
                pa = rand_addr(ps);
                pd = $urandom;
                req = 1'b1; we = pw; size = ps; addr = pa; wdata = pd;
            end else begin
                check("t7_ack", 32'(ack0), 32'd1);
                model_access(0, pw, ps, pa, pd, e, exp_rd);
                check("t7_err", 32'(err0), 32'(e));
                check("t7_rdata", rdata0, exp_rd);
                req = 1'b1; we = 1'b1; size = 2'($urandom); addr = $urandom; wdata = $urandom;
            end
            @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);
        check("t7_tail_ack", 32'(ack0), 32'd0);

        // Read back a few locations on both instances after the random traffic
        for (int t = 0; t < 8; t++) begin
            pa = 32'($urandom_range(0, 63)) * 32'd4;
            do_access(0, 1'b0, 2'b00, pa, 32'h0, obs);
            do_access(1, 1'b0, 2'b00, pa, 32'h0, obs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
